// File: rtl/gmii_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : gmii_tx_arbiter_if
// Brief   : Frame-source side and arbitrated GMII side of the TX arbiter.
// Revision: 1.0
// ============================================================================
interface gmii_tx_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   src_tx_en;
    logic [8*N-1:0] src_txd;
    logic           gmii_tx_en;
    logic [7:0]     gmii_txd;

    // Sources and the MAC-side consumer together form the master view.
    modport master (
        output req, src_tx_en, src_txd,
        input  gnt, gmii_tx_en, gmii_txd
    );

    modport slave (
        input  req, src_tx_en, src_txd,
        output gnt, gmii_tx_en, gmii_txd
    );
endinterface
`default_nettype wire

// File: rtl/gmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : gmii_tx_arbiter
// Brief   : Round-robin GMII TX arbiter, one frame per grant, with IFG,
//           start timeout, oversize truncation and link-loss abort.
// Revision: 1.0
// ============================================================================
module gmii_tx_arbiter #(
    parameter int N        = 3,
    parameter int IFG      = 12,
    parameter int START_TO = 64,
    parameter int MAX_LEN  = 1526
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         link,
    input  wire logic         eth_10_100m_en,
    gmii_tx_arbiter_if.slave  bus,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_oversize
);

    localparam int          c_PTR_W    = $clog2(N);
    localparam logic [15:0] c_IFG_1G   = 16'(IFG);
    localparam logic [15:0] c_IFG_SLOW = 16'(2 * IFG);
    localparam logic [15:0] c_TO_LAST  = 16'(START_TO - 1);
    localparam logic [15:0] c_MAX_LEN  = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_SEND  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_gnt;
    logic [c_PTR_W-1:0]   r_sel;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic                 r_tx_en;
    logic [7:0]           r_txd;
    logic [15:0]          r_wait_cnt;
    logic [15:0]          r_byte_cnt;
    logic [15:0]          r_gap_cnt;
    logic [15:0]          r_ifg_eff;
    logic                 r_err_timeout;
    logic                 r_err_oversize;

    logic [c_PTR_W-1:0]   w_sel;
    logic [c_PTR_W-1:0]   w_cand;
    logic                 w_found;
    logic                 w_src_en;
    logic [7:0]           w_src_d;
    logic [15:0]          w_ifg_eff;

    function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // First requester at or after the round-robin pointer, wrapping mod N.
    always_comb begin
        w_sel   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (int'(r_rr_ptr) + k >= N)
                w_cand = c_PTR_W'(int'(r_rr_ptr) + k - N);
            else
                w_cand = c_PTR_W'(int'(r_rr_ptr) + k);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_src_en  = bus.src_tx_en[r_sel];
    assign w_src_d   = bus.src_txd[{r_sel, 3'b000} +: 8];
    assign w_ifg_eff = eth_10_100m_en ? c_IFG_SLOW : c_IFG_1G;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_gnt          <= '0;
            r_sel          <= '0;
            r_rr_ptr       <= '0;
            r_tx_en        <= 1'b0;
            r_txd          <= 8'd0;
            r_wait_cnt     <= 16'd0;
            r_byte_cnt     <= 16'd0;
            r_gap_cnt      <= 16'd0;
            r_ifg_eff      <= 16'd0;
            r_err_timeout  <= 1'b0;
            r_err_oversize <= 1'b0;
        end else begin
            r_err_timeout  <= 1'b0;
            r_err_oversize <= 1'b0;
            r_tx_en        <= 1'b0;
            r_txd          <= 8'd0;
            if (!link) begin
                // Link loss cuts any frame silently and overrides every other event.
                r_state <= S_IDLE;
                r_gnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_found) begin
                            r_gnt      <= N'(1) << w_sel;
                            r_sel      <= w_sel;
                            r_rr_ptr   <= (w_sel == c_PTR_W'(N - 1)) ? '0 : w_sel + 1'b1;
                            r_wait_cnt <= 16'd0;
                            r_state    <= S_GRANT;
                        end
                    end
                    S_GRANT: begin
                        if (w_src_en) begin
                            r_tx_en    <= 1'b1;
                            r_txd      <= w_src_d;
                            r_byte_cnt <= 16'd1;
                            r_state    <= S_SEND;
                        end else if (!bus.req[r_sel]) begin
                            r_gnt   <= '0;
                            r_state <= S_IDLE;
                        end else if (r_wait_cnt == c_TO_LAST) begin
                            r_err_timeout <= 1'b1;
                            r_gnt         <= '0;
                            r_gap_cnt     <= 16'd0;
                            r_ifg_eff     <= w_ifg_eff;
                            r_state       <= S_GAP;
                        end else begin
                            r_wait_cnt <= f_sat_inc(r_wait_cnt);
                        end
                    end
                    S_SEND: begin
                        if (!w_src_en) begin
                            r_gnt     <= '0;
                            r_gap_cnt <= 16'd0;
                            r_ifg_eff <= w_ifg_eff;
                            r_state   <= S_GAP;
                        end else if (r_byte_cnt == c_MAX_LEN) begin
                            r_err_oversize <= 1'b1;
                            r_state        <= S_DRAIN;
                        end else begin
                            r_tx_en    <= 1'b1;
                            r_txd      <= w_src_d;
                            r_byte_cnt <= f_sat_inc(r_byte_cnt);
                        end
                    end
                    S_DRAIN: begin
                        // Grant is kept so the source still sees its frame as active.
                        if (!w_src_en) begin
                            r_gnt     <= '0;
                            r_gap_cnt <= 16'd0;
                            r_ifg_eff <= w_ifg_eff;
                            r_state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == r_ifg_eff - 16'd1)
                            r_state <= S_IDLE;
                        else
                            r_gap_cnt <= f_sat_inc(r_gap_cnt);
                    end
                    default: begin
                        r_gnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.gmii_tx_en = r_tx_en;
    assign bus.gmii_txd   = r_txd;
    assign busy           = (r_state != S_IDLE);
    assign err_timeout    = r_err_timeout;
    assign err_oversize   = r_err_oversize;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_gmii_tx_arbiter
// Brief   : Directed self-checking bench for gmii_tx_arbiter.
// Revision: 1.0
// ============================================================================
module tb_gmii_tx_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic link;
    logic eth;
    logic busy;
    logic err_timeout;
    logic err_oversize;

    int checks = 0;
    int errors = 0;
    int w;
    int n;
    int n_out;
    int n_ovf;
    int data_err;
    int gnt_lost;
    logic [8:0] exp9;

    gmii_tx_arbiter_if #(.N(N)) bif ();

    gmii_tx_arbiter #(
        .N        (N),
        .IFG      (12),
        .START_TO (64),
        .MAX_LEN  (1526)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .link           (link),
        .eth_10_100m_en (eth),
        .bus            (bif),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .err_oversize   (err_oversize)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        link          = 1'b1;
        eth           = 1'b0;
        bif.req       = '0;
        bif.src_tx_en = '0;
        bif.src_txd   = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_gnt(input string tag, input logic [2:0] exp, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (bif.gnt === 3'b000 && waited < 300);
        check(tag, {29'd0, bif.gnt}, {29'd0, exp});
    endtask

    // Source reacts one cycle after seeing its grant, then streams len bytes.
    task automatic send_frame(input string tag, input int src, input int len,
                              input logic [7:0] base, input bit drop_req);
        logic [2:0] oh;
        oh = 3'b001 << src;
        tick();
        check({tag, " pre-first idle"}, {31'd0, bif.gmii_tx_en}, 32'd0);
        for (int b = 0; b < len; b++) begin
            bif.src_tx_en[src]         = 1'b1;
            bif.src_txd[8*src +: 8]    = base + 8'(b);
            tick();
            check($sformatf("%s byte %0d", tag, b),
                  {20'd0, bif.gnt, bif.gmii_tx_en, bif.gmii_txd},
                  {20'd0, oh, 1'b1, base + 8'(b)});
        end
        bif.src_tx_en[src]      = 1'b0;
        bif.src_txd[8*src +: 8] = 8'd0;
        if (drop_req) bif.req[src] = 1'b0;
        tick();
        check({tag, " end"}, {20'd0, bif.gnt, bif.gmii_tx_en, bif.gmii_txd}, 32'd0);
    endtask

    initial begin
        // ---------------- reset state
        do_reset();
        check("rst gnt", {29'd0, bif.gnt}, 32'd0);
        check("rst tx_en/txd", {23'd0, bif.gmii_tx_en, bif.gmii_txd}, 32'd0);
        check("rst busy/errs", {29'd0, busy, err_timeout, err_oversize}, 32'd0);

        // ---------------- 1: single 60-byte frame from src0
        bif.req = 3'b001;
        wait_gnt("t1 gnt", 3'b001, w);
        send_frame("t1", 0, 60, 8'h10, 1'b1);
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b0 && n < 100);
        check("t1 gnt-drop to idle", n, 12);

        // ---------------- 2: all three requesting, order 0,1,2,0
        do_reset();
        bif.req = 3'b111;
        wait_gnt("t2 gnt0", 3'b001, w);
        send_frame("t2 f0", 0, 64, 8'h00, 1'b0);
        wait_gnt("t2 gnt1", 3'b010, w);
        check("t2 idle gap 0-1", w + 2, 15);
        send_frame("t2 f1", 1, 64, 8'h40, 1'b0);
        wait_gnt("t2 gnt2", 3'b100, w);
        check("t2 idle gap 1-2", w + 2, 15);
        send_frame("t2 f2", 2, 64, 8'h80, 1'b0);
        wait_gnt("t2 gnt0 again", 3'b001, w);
        check("t2 idle gap 2-0", w + 2, 15);
        bif.req = 3'b001;
        send_frame("t2 f3", 0, 64, 8'hC0, 1'b1);

        // ---------------- 3: 10/100 mode doubles the gap
        do_reset();
        eth     = 1'b1;
        bif.req = 3'b011;
        wait_gnt("t3 gnt0", 3'b001, w);
        send_frame("t3 f0", 0, 64, 8'h20, 1'b1);
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b0 && n < 100);
        check("t3 gap after f0", n, 24);
        wait_gnt("t3 gnt1", 3'b010, w);
        send_frame("t3 f1", 1, 64, 8'h60, 1'b1);
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b0 && n < 100);
        check("t3 gap after f1", n, 24);

        // ---------------- 4: start timeout on src1, src2 next
        do_reset();
        bif.req = 3'b110;
        wait_gnt("t4 gnt1", 3'b010, w);
        n = 0;
        do begin tick(); n++; end while (err_timeout !== 1'b1 && n < 200);
        check("t4 timeout latency", n, 64);
        check("t4 gnt after timeout", {29'd0, bif.gnt}, 32'd0);
        bif.req[1]       = 1'b0;
        bif.src_tx_en[0] = 1'b1;
        bif.src_txd[7:0] = 8'hEE;
        tick();
        check("t4 timeout pulse width", {31'd0, err_timeout}, 32'd0);
        wait_gnt("t4 gnt2", 3'b100, w);
        send_frame("t4 f2", 2, 8, 8'hA0, 1'b1);
        bif.src_tx_en[0] = 1'b0;
        bif.src_txd[7:0] = 8'h00;

        // ---------------- 5: oversize truncation at MAX_LEN
        do_reset();
        bif.req = 3'b001;
        wait_gnt("t5 gnt0", 3'b001, w);
        tick();
        n_out = 0; n_ovf = 0; data_err = 0; gnt_lost = 0;
        for (int b = 0; b < 2000; b++) begin
            bif.src_tx_en[0] = 1'b1;
            bif.src_txd[7:0] = 8'(b);
            tick();
            if (bif.gmii_tx_en === 1'b1) n_out++;
            if (err_oversize === 1'b1) n_ovf++;
            exp9 = (b < 1526) ? {1'b1, 8'(b)} : 9'd0;
            if ({bif.gmii_tx_en, bif.gmii_txd} !== exp9) data_err++;
            if (bif.gnt !== 3'b001) gnt_lost++;
        end
        check("t5 bytes out", n_out, 1526);
        check("t5 oversize pulses", n_ovf, 1);
        check("t5 data mismatches", data_err, 0);
        check("t5 gnt drops while held", gnt_lost, 0);
        bif.src_tx_en[0] = 1'b0;
        bif.req          = 3'b000;
        tick();
        check("t5 gnt after tx_en falls", {29'd0, bif.gnt}, 32'd0);
        check("t5 busy in gap", {31'd0, busy}, 32'd1);

        // ---------------- 6: link loss mid-frame, then recovery
        do_reset();
        bif.req = 3'b001;
        wait_gnt("t6 gnt0", 3'b001, w);
        tick();
        for (int b = 0; b < 30; b++) begin
            bif.src_tx_en[0] = 1'b1;
            bif.src_txd[7:0] = 8'h30 + 8'(b);
            tick();
        end
        check("t6 mid-frame", {23'd0, bif.gmii_tx_en, bif.gmii_txd}, {23'd0, 1'b1, 8'h4D});
        link = 1'b0;
        tick();
        check("t6 link lost out", {20'd0, bif.gnt, bif.gmii_tx_en, bif.gmii_txd}, 32'd0);
        check("t6 link lost busy/errs", {29'd0, busy, err_timeout, err_oversize}, 32'd0);
        tick();
        check("t6 link down no grant", {29'd0, bif.gnt}, 32'd0);
        link             = 1'b1;
        bif.src_tx_en[0] = 1'b0;
        bif.src_txd[7:0] = 8'h00;
        bif.req          = 3'b010;
        wait_gnt("t6 gnt1 after link", 3'b010, w);
        send_frame("t6 f1", 1, 16, 8'h70, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
